serial_to_parallel_rx: RTL and testbench

Receive-side stage that consumes the serial stream produced by the team's 4-bit parallel-to-serial converter (`serial`/`valid`/`empty`, MSB first). It reassembles the stream into WIDTH-bit words, checks the framing, and buffers completed words in a 2-entry output queue with a valid/ready handshake. Framing errors and overflow are reported through flags and counters.

---
 rtl/serial_to_parallel_rx_if.sv | 22 ++
 rtl/serial_to_parallel_rx.sv | 167 ++++++++++++++++
 tb/tb_serial_to_parallel_rx.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_to_parallel_rx_if.sv
// Serial-in / word-out handshake bundle for the serial-to-parallel receiver.
// The master drives the serial stream and consumes words; the slave is the receiver.
interface serial_to_parallel_rx_if #(
  parameter int WIDTH = 4
);
  logic             serial_i;
  logic             valid_i;
  logic             empty_i;
  logic [WIDTH-1:0] out_data_o;
  logic             out_valid_o;
  logic             out_ready_i;

  modport master (
    output serial_i, valid_i, empty_i, out_ready_i,
    input  out_data_o, out_valid_o
  );

  modport slave (
    input  serial_i, valid_i, empty_i, out_ready_i,
    output out_data_o, out_valid_o
  );
endinterface

// File: rtl/serial_to_parallel_rx.sv
// Reassembles an MSB-first serial stream into WIDTH-bit words, checks frame gaps,
// and buffers finished words in a 2-entry valid/ready queue.
module serial_to_parallel_rx #(
  parameter int WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  serial_to_parallel_rx_if.slave     bus,
  input  logic                       clr_i,
  output logic                       busy_o,
  output logic                       frame_err_o,
  output logic                       overflow_o,
  output logic [7:0]                 word_cnt_o,
  output logic [7:0]                 err_cnt_o
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] shreg_q;
  logic             frame_err_q;

  logic             both;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] push_word;

  logic [WIDTH-1:0] mem_q [2];
  logic             rd_q;
  logic [1:0]       occ_q, occ_d;
  logic             pop, push_ok;
  logic             wr_idx;

  logic             overflow_q;
  logic [7:0]       word_cnt_q;
  logic [7:0]       err_cnt_q;

  assign both      = bus.valid_i & bus.empty_i;
  assign push_word = {shreg_q[WIDTH-2:0], bus.serial_i};

  // Event decode shared by the FSM, the queue and the counters.
  always_comb begin
    done = 1'b0;
    err  = 1'b0;
    if (both) begin
      err = 1'b1;
    end else begin
      case (state_q)
        SHIFT: begin
          if (bus.valid_i)      done = (cnt_q == LAST);
          else if (bus.empty_i) err  = 1'b1;
        end
        GAP:     err = bus.valid_i;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= err;
      if (both) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (bus.valid_i) begin
              state_q <= SHIFT;
              cnt_q   <= CW'(1);
              shreg_q <= WIDTH'(bus.serial_i);
            end
          end
          SHIFT: begin
            if (bus.valid_i) begin
              shreg_q <= push_word;
              if (done) begin
                state_q <= GAP;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end else if (bus.empty_i) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end
          end
          GAP: begin
            // A bit arriving without a gap still starts the next word.
            if (bus.valid_i) begin
              state_q <= SHIFT;
              cnt_q   <= CW'(1);
              shreg_q <= WIDTH'(bus.serial_i);
            end else if (bus.empty_i) begin
              state_q <= IDLE;
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  // Write slot is rd+occ mod 2; when full with a pop this is the slot being freed.
  assign pop     = (occ_q != 2'd0) & bus.out_ready_i;
  assign push_ok = done & ((occ_q != 2'd2) | pop);
  assign wr_idx  = rd_q ^ occ_q[0];

  always_comb begin
    occ_d = occ_q;
    case ({push_ok, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_q     <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push_ok) mem_q[wr_idx] <= push_word;
      if (pop)     rd_q <= ~rd_q;
      occ_q <= occ_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
      word_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else if (clr_i) begin
      overflow_q <= 1'b0;
      word_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      if (done && !push_ok)          overflow_q <= 1'b1;
      if (push_ok)                   word_cnt_q <= word_cnt_q + 8'd1;
      if (err && err_cnt_q != 8'hFF) err_cnt_q  <= err_cnt_q + 8'd1;
    end
  end

  assign bus.out_valid_o = (occ_q != 2'd0);
  assign bus.out_data_o  = (occ_q != 2'd0) ? mem_q[rd_q] : '0;
  assign busy_o          = (state_q == SHIFT);
  assign frame_err_o     = frame_err_q;
  assign overflow_o      = overflow_q;
  assign word_cnt_o      = word_cnt_q;
  assign err_cnt_o       = err_cnt_q;

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Bench for serial_to_parallel_rx: directed scenarios plus random traffic checked
// against a bit-count/arithmetic reference model of framing and the output queue.
module tb_serial_to_parallel_rx;
  localparam int W = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr_i;
  logic       busy_o, frame_err_o, overflow_o;
  logic [7:0] word_cnt_o, err_cnt_o;
  int         tests = 0;
  int         fails = 0;

  serial_to_parallel_rx_if #(.WIDTH(W)) bus ();

  serial_to_parallel_rx #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .clr_i      (clr_i),
    .busy_o     (busy_o),
    .frame_err_o(frame_err_o),
    .overflow_o (overflow_o),
    .word_cnt_o (word_cnt_o),
    .err_cnt_o  (err_cnt_o)
  );

  always #5 clk = ~clk;

  // Reference model: bits gathered so far, their value, whether a gap is owed.
  int         m_bits, m_val, m_wc, m_ec;
  bit         m_gap, m_ovf, m_ferr;
  logic [W-1:0] m_q[$];

  task automatic model_reset();
    m_bits = 0; m_val = 0; m_wc = 0; m_ec = 0;
    m_gap = 0; m_ovf = 0; m_ferr = 0;
    m_q.delete();
  endtask

  // Apply inputs for one cycle, advance the model over that edge, settle 1 time unit.
  task automatic drive(input bit v, input bit e, input bit s, input bit rdy, input bit clr);
    bit err, done, pop;
    logic [W-1:0] word;
    bus.valid_i = v; bus.empty_i = e; bus.serial_i = s;
    bus.out_ready_i = rdy; clr_i = clr;
    @(posedge clk);
    err = 0; done = 0; word = '0;
    pop = (m_q.size() > 0) && rdy;
    if (v && e) begin
      err = 1; m_bits = 0; m_gap = 0;
    end else if (v) begin
      if (m_bits == 0) begin
        err = m_gap; m_gap = 0; m_bits = 1; m_val = int'(s);
      end else begin
        m_val = m_val * 2 + int'(s);
        m_bits++;
        if (m_bits == W) begin
          done = 1; word = W'(m_val); m_bits = 0; m_gap = 1;
        end
      end
    end else if (e) begin
      err = (m_bits > 0); m_bits = 0; m_gap = 0;
    end
    if (pop) void'(m_q.pop_front());
    if (done) begin
      if (m_q.size() < 2) begin m_q.push_back(word); m_wc = (m_wc + 1) % 256; end
      else m_ovf = 1;
    end
    if (err && m_ec < 255) m_ec++;
    m_ferr = err;
    if (clr) begin m_wc = 0; m_ec = 0; m_ovf = 0; end
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit rdy);
    for (int i = W - 1; i >= 0; i--) drive(1, 0, w[i], rdy, 0);
    drive(0, 1, 0, rdy, 0);
  endtask

  task automatic test_reset();
    rst_n = 0; clr_i = 0;
    bus.valid_i = 0; bus.empty_i = 0; bus.serial_i = 0; bus.out_ready_i = 0;
    model_reset();
    #12;
    tests++; if ({bus.out_valid_o, busy_o, frame_err_o, overflow_o} !== 4'b0) begin
      fails++; $display("FAIL reset_flags: got %b want 0000", {bus.out_valid_o, busy_o, frame_err_o, overflow_o}); end
    tests++; if ({bus.out_data_o, word_cnt_o, err_cnt_o} !== 20'h0) begin
      fails++; $display("FAIL reset_values: got %h want 0", {bus.out_data_o, word_cnt_o, err_cnt_o}); end
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_nominal();
    logic [W-1:0] w = 4'hB;
    bit seen = 0;
    for (int i = W - 1; i >= 0; i--) begin drive(1, 0, w[i], 0, 0); seen |= frame_err_o; end
    tests++; if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== 4'hB) begin
      fails++; $display("FAIL nominal_word: got v=%b d=%h want v=1 d=b", bus.out_valid_o, bus.out_data_o); end
    tests++; if (word_cnt_o !== 8'd1) begin
      fails++; $display("FAIL nominal_wcnt: got %0d want 1", word_cnt_o); end
    drive(0, 1, 0, 0, 0); seen |= frame_err_o;
    tests++; if (seen !== 1'b0) begin
      fails++; $display("FAIL nominal_ferr: got %b want 0", seen); end
    drive(0, 0, 0, 1, 0);
    tests++; if (bus.out_valid_o !== 1'b0) begin
      fails++; $display("FAIL nominal_pop: got %b want 0", bus.out_valid_o); end
  endtask

  task automatic test_backpressure();
    drive(0, 0, 0, 0, 1);
    send_word(4'h3, 0); send_word(4'h5, 0); send_word(4'h9, 0);
    tests++; if (overflow_o !== 1'b1 || word_cnt_o !== 8'd2) begin
      fails++; $display("FAIL bp_overflow: got ovf=%b wc=%0d want ovf=1 wc=2", overflow_o, word_cnt_o); end
    tests++; if (bus.out_data_o !== 4'h3) begin
      fails++; $display("FAIL bp_head: got %h want 3", bus.out_data_o); end
    drive(0, 0, 0, 1, 0);
    tests++; if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== 4'h5) begin
      fails++; $display("FAIL bp_second: got v=%b d=%h want v=1 d=5", bus.out_valid_o, bus.out_data_o); end
    drive(0, 0, 0, 1, 0);
    tests++; if (bus.out_valid_o !== 1'b0) begin
      fails++; $display("FAIL bp_drain: got %b want 0", bus.out_valid_o); end
    drive(0, 0, 0, 0, 1);
  endtask

  task automatic test_short_frame();
    drive(1, 0, 1, 0, 0); drive(1, 0, 1, 0, 0);
    tests++; if (busy_o !== 1'b1) begin
      fails++; $display("FAIL short_busy: got %b want 1", busy_o); end
    drive(0, 1, 0, 0, 0);
    tests++; if (frame_err_o !== 1'b1 || err_cnt_o !== 8'd1 || busy_o !== 1'b0 || bus.out_valid_o !== 1'b0) begin
      fails++; $display("FAIL short_err: got fe=%b ec=%0d busy=%b v=%b want 1 1 0 0",
                        frame_err_o, err_cnt_o, busy_o, bus.out_valid_o); end
    drive(0, 0, 0, 0, 0);
    tests++; if (frame_err_o !== 1'b0) begin
      fails++; $display("FAIL short_pulse: got %b want 0", frame_err_o); end
    send_word(4'hC, 0);
    tests++; if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== 4'hC) begin
      fails++; $display("FAIL short_next: got v=%b d=%h want v=1 d=c", bus.out_valid_o, bus.out_data_o); end
    drive(0, 0, 0, 1, 0);
  endtask

  task automatic test_missing_gap();
    logic [W-1:0] a = 4'hA, b = 4'h7;
    for (int i = W - 1; i >= 0; i--) drive(1, 0, a[i], 0, 0);
    tests++; if (bus.out_data_o !== 4'hA || frame_err_o !== 1'b0) begin
      fails++; $display("FAIL gap_first: got d=%h fe=%b want d=a fe=0", bus.out_data_o, frame_err_o); end
    drive(1, 0, b[3], 0, 0);
    tests++; if (frame_err_o !== 1'b1 || err_cnt_o !== 8'd2) begin
      fails++; $display("FAIL gap_err: got fe=%b ec=%0d want fe=1 ec=2", frame_err_o, err_cnt_o); end
    for (int i = W - 2; i >= 0; i--) drive(1, 0, b[i], 0, 0);
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    tests++; if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== 4'h7) begin
      fails++; $display("FAIL gap_second: got v=%b d=%h want v=1 d=7", bus.out_valid_o, bus.out_data_o); end
    drive(0, 0, 0, 1, 0);
  endtask

  task automatic test_full_pushpop();
    logic [W-1:0] w = 4'h4;
    send_word(4'h1, 0); send_word(4'h2, 0);
    for (int i = W - 1; i >= 0; i--) drive(1, 0, w[i], (i == 0), 0);
    tests++; if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== 4'h2 || overflow_o !== 1'b0) begin
      fails++; $display("FAIL full_pp: got v=%b d=%h ovf=%b want v=1 d=2 ovf=0",
                        bus.out_valid_o, bus.out_data_o, overflow_o); end
    drive(0, 1, 0, 0, 0);
    tests++; if (bus.out_data_o !== 4'h2) begin
      fails++; $display("FAIL full_hold: got %h want 2", bus.out_data_o); end
    drive(0, 0, 0, 1, 0);
    tests++; if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== 4'h4) begin
      fails++; $display("FAIL full_tail: got v=%b d=%h want v=1 d=4", bus.out_valid_o, bus.out_data_o); end
    drive(0, 0, 0, 1, 0);
  endtask

  task automatic test_reset_clear();
    send_word(4'h5, 0);
    drive(1, 0, 1, 0, 0); drive(1, 0, 0, 0, 0);
    #2 rst_n = 0;
    model_reset();
    #1;
    tests++; if ({bus.out_valid_o, busy_o, frame_err_o, overflow_o} !== 4'b0 ||
                 {bus.out_data_o, word_cnt_o, err_cnt_o} !== 20'h0) begin
      fails++; $display("FAIL async_reset: got flags=%b vals=%h want 0",
                        {bus.out_valid_o, busy_o, frame_err_o, overflow_o}, {bus.out_data_o, word_cnt_o, err_cnt_o}); end
    #3 rst_n = 1;
    send_word(4'hF, 0);
    tests++; if (bus.out_data_o !== 4'hF || word_cnt_o !== 8'd1) begin
      fails++; $display("FAIL reset_next: got d=%h wc=%0d want d=f wc=1", bus.out_data_o, word_cnt_o); end
    send_word(4'h6, 0); send_word(4'h8, 0);
    drive(1, 0, 1, 0, 0); drive(0, 1, 0, 0, 0);
    tests++; if (overflow_o !== 1'b1 || err_cnt_o !== 8'd1 || word_cnt_o !== 8'd2) begin
      fails++; $display("FAIL pre_clr: got ovf=%b ec=%0d wc=%0d want 1 1 2", overflow_o, err_cnt_o, word_cnt_o); end
    drive(0, 0, 0, 0, 1);
    tests++; if ({overflow_o, word_cnt_o, err_cnt_o} !== 17'h0) begin
      fails++; $display("FAIL clr: got ovf=%b wc=%0d ec=%0d want 0", overflow_o, word_cnt_o, err_cnt_o); end
    drive(0, 0, 0, 1, 0); drive(0, 0, 0, 1, 0);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 260; i++) drive(1, 1, 0, 1, 0);
    tests++; if (err_cnt_o !== 8'd255 || frame_err_o !== 1'b1) begin
      fails++; $display("FAIL err_sat: got ec=%0d fe=%b want 255 1", err_cnt_o, frame_err_o); end
    drive(0, 0, 0, 1, 1);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 257; i++) send_word(W'($urandom), 1);
    tests++; if (word_cnt_o !== 8'd1) begin
      fails++; $display("FAIL wcnt_wrap: got %0d want 1", word_cnt_o); end
    drive(0, 0, 0, 1, 0);
  endtask

  task automatic test_random();
    bit v, e, s, rdy, clr;
    for (int n = 0; n < 4000; n++) begin
      v   = ($urandom % 100) < 65;
      e   = ($urandom % 100) < (v ? 6 : 35);
      s   = $urandom % 2;
      rdy = ($urandom % 100) < 40;
      clr = ($urandom % 150) == 0;
      drive(v, e, s, rdy, clr);
      tests++; if (bus.out_valid_o !== (m_q.size() > 0) ||
                   (m_q.size() > 0 && bus.out_data_o !== m_q[0])) begin
        fails++; $display("FAIL rnd_queue@%0d: got v=%b d=%h want v=%b d=%h", n,
                          bus.out_valid_o, bus.out_data_o, m_q.size() > 0, (m_q.size() > 0) ? m_q[0] : 4'h0); end
      tests++; if (busy_o !== (m_bits > 0) || frame_err_o !== m_ferr || overflow_o !== m_ovf) begin
        fails++; $display("FAIL rnd_flags@%0d: got busy=%b fe=%b ovf=%b want %b %b %b", n,
                          busy_o, frame_err_o, overflow_o, m_bits > 0, m_ferr, m_ovf); end
      tests++; if (word_cnt_o !== 8'(m_wc) || err_cnt_o !== 8'(m_ec)) begin
        fails++; $display("FAIL rnd_cnt@%0d: got wc=%0d ec=%0d want %0d %0d", n,
                          word_cnt_o, err_cnt_o, m_wc, m_ec); end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_short_frame();
    test_missing_gap();
    test_full_pushpop();
    test_reset_clear();
    test_saturation();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
